// File: rtl/ps2_pkg.sv
// Shared types and framing constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// Consumer-side port bundle of the PS/2 receiver: scan-code FIFO read port plus status.
// Handshake: a byte moves on every cycle where rd_valid and rd_ready are both 1;
// rd_valid never depends on rd_ready, and rd_data is stable while rd_valid=1 and no pop occurs.
interface ps2_keyboard_rx_if #(
    parameter int FIFO_DEPTH = 8
);
    import ps2_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          rd_ready;
    logic          rd_valid;
    logic [7:0]    rd_data;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          frame_err;
    ps2_state_t    state_dbg;

    modport master (
        input  rd_ready,
        output rd_valid, rd_data, fifo_count, overflow, frame_err, state_dbg
    );

    modport slave (
        output rd_ready,
        input  rd_valid, rd_data, fifo_count, overflow, frame_err, state_dbg
    );

endinterface

// File: rtl/ps2_sync_fifo.sv
// First-word fall-through byte FIFO with extra-MSB pointers and a sticky overflow flag.
module ps2_sync_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop_req,
    output logic                     rd_valid,
    output logic [7:0]               rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wptr_q, rptr_q;
    logic [7:0]  mem_q [DEPTH];
    logic        overflow_q;
    logic        empty, full, do_pop, do_push;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = ~empty & pop_req;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            if (push && full && !do_pop) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data;
    end

    assign rd_valid = ~empty;
    assign rd_data  = empty ? 8'h00 : mem_q[rptr_q[AW-1:0]];
    assign count    = wptr_q - rptr_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard frame receiver: synchronizes the pins, checks start/odd-parity/stop, buffers good bytes.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    ps2_keyboard_rx_if.master rx
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic clk_s1_q, clk_s2_q, clk_prev_q;
    logic dat_s1_q, dat_s2_q;
    logic fall;

    ps2_state_t    state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          frame_err_q, frame_err_d;
    logic          push;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= ps2_data;
            dat_s2_q   <= dat_s1_q;
        end
    end

    assign fall = clk_prev_q & ~clk_s2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            to_cnt_q    <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            to_cnt_q    <= to_cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
        to_cnt_d    = (state_q == IDLE || fall) ? '0 : to_cnt_q + 1'b1;

        // A stalled keyboard clock abandons the partial byte rather than resyncing mid-frame.
        if (state_q != IDLE && to_cnt_q == TO_LAST) begin
            state_d     = IDLE;
            bitcnt_d    = '0;
            shift_d     = '0;
            to_cnt_d    = '0;
            frame_err_d = 1'b1;
        end else if (fall) begin
            case (state_q)
                IDLE: begin
                    if (dat_s2_q == START_BIT) begin
                        state_d  = DATA;
                        bitcnt_d = '0;
                        shift_d  = '0;
                    end
                end
                DATA: begin
                    shift_d[bitcnt_q] = dat_s2_q;
                    bitcnt_d          = bitcnt_q + 1'b1;
                    if (bitcnt_q == 3'(DATA_BITS - 1)) state_d = PARITY;
                end
                PARITY: begin
                    parity_d = dat_s2_q;
                    state_d  = STOP;
                end
                STOP: begin
                    if (dat_s2_q == STOP_BIT && ^{shift_q, parity_q}) push = 1'b1;
                    else                                              frame_err_d = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    ps2_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (push),
        .push_data (shift_q),
        .pop_req   (rx.rd_ready),
        .rd_valid  (rx.rd_valid),
        .rd_data   (rx.rd_data),
        .count     (rx.fifo_count),
        .overflow  (rx.overflow)
    );

    assign rx.frame_err = frame_err_q;
    assign rx.state_dbg = state_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: framing, parity, FIFO fill/overflow, timeout and reset recovery.
module tb_ps2_keyboard_rx;
    import ps2_pkg::*;

    localparam int FIFO_DEPTH = 8;
    localparam int TIMEOUT    = 500;
    localparam int HALF       = 20;
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   err_pulses = 0;

    ps2_keyboard_rx_if #(.FIFO_DEPTH(FIFO_DEPTH)) rx_if ();

    ps2_keyboard_rx #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx       (rx_if.master)
    );

    // clock / reset
    always #5 clk = ~clk;

    always @(negedge clk) if (rx_if.frame_err === 1'b1) err_pulses++;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // driver tasks
    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit par_ok, input logic stop);
        logic par;
        par = par_ok ? ~^b : ^b;
        return {stop, par, b, 1'b0};
    endfunction

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_bits(input logic [10:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    endtask

    task automatic pop_expect(input logic [7:0] exp, input string name);
        @(negedge clk);
        checks++;
        if (rx_if.rd_valid !== 1'b1 || rx_if.rd_data !== exp) begin
            errors++;
            $display("FAIL %s: rd_valid=%b rd_data=%h required 1/%h", name, rx_if.rd_valid, rx_if.rd_data, exp);
        end
        rx_if.rd_ready = 1'b1;
        @(negedge clk);
        rx_if.rd_ready = 1'b0;
    endtask

    task automatic check_count(input logic [CW-1:0] exp, input string name);
        checks++;
        if (rx_if.fifo_count !== exp) begin
            errors++;
            $display("FAIL %s: fifo_count=%0d required %0d", name, rx_if.fifo_count, exp);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (rx_if.rd_valid !== 1'b0 || rx_if.rd_data !== 8'h00 || rx_if.fifo_count !== '0 ||
            rx_if.overflow !== 1'b0 || rx_if.frame_err !== 1'b0 || rx_if.state_dbg !== IDLE) begin
            errors++;
            $display("FAIL reset_outputs: v=%b d=%h c=%0d ov=%b fe=%b st=%0d required 0/00/0/0/0/0",
                     rx_if.rd_valid, rx_if.rd_data, rx_if.fifo_count, rx_if.overflow,
                     rx_if.frame_err, rx_if.state_dbg);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_good_frame();
        logic [10:0] f;
        int base;
        base = err_pulses;
        f = mk_frame(8'h1C, 1'b1, 1'b1);
        send_bits(f, 10);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rx_if.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: rd_valid=%b required 0 two edges after stop fall", rx_if.rd_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rx_if.rd_valid !== 1'b1 || rx_if.rd_data !== 8'h1C) begin
            errors++;
            $display("FAIL latency_push: rd_valid=%b rd_data=%h required 1/1c", rx_if.rd_valid, rx_if.rd_data);
        end
        check_count(4'd1, "good_count");
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        checks++;
        if (err_pulses != base) begin
            errors++;
            $display("FAIL good_no_err: frame_err pulses=%0d required 0", err_pulses - base);
        end
        pop_expect(8'h1C, "good_pop");
        @(negedge clk);
        checks++;
        if (rx_if.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL good_empty: rd_valid=%b required 0", rx_if.rd_valid);
        end
    endtask

    task automatic test_bad_frames();
        int base;
        base = err_pulses;
        send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 11);
        repeat (5) @(negedge clk);
        checks++;
        if (err_pulses - base != 1) begin
            errors++;
            $display("FAIL bad_parity_err: pulses=%0d required 1", err_pulses - base);
        end
        check_count(4'd0, "bad_parity_count");
        base = err_pulses;
        send_bits(mk_frame(8'hF0, 1'b1, 1'b0), 11);
        repeat (5) @(negedge clk);
        checks++;
        if (err_pulses - base != 1) begin
            errors++;
            $display("FAIL bad_stop_err: pulses=%0d required 1", err_pulses - base);
        end
        check_count(4'd0, "bad_stop_count");
    endtask

    task automatic test_overflow();
        logic [7:0] b;
        for (int i = 1; i <= 9; i++) begin
            b = 8'(i);
            send_bits(mk_frame(b, 1'b1, 1'b1), 11);
        end
        repeat (5) @(negedge clk);
        check_count(4'd8, "ovf_count");
        checks++;
        if (rx_if.overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag: overflow=%b required 1", rx_if.overflow);
        end
        for (int i = 1; i <= 8; i++) begin
            b = 8'(i);
            pop_expect(b, "ovf_pop");
        end
        @(negedge clk);
        checks++;
        if (rx_if.overflow !== 1'b1 || rx_if.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_sticky: overflow=%b rd_valid=%b required 1/0", rx_if.overflow, rx_if.rd_valid);
        end
    endtask

    task automatic test_mid_frame_reset();
        int base;
        send_bits(mk_frame(8'h55, 1'b1, 1'b1), 11);
        repeat (5) @(negedge clk);
        check_count(4'd1, "pre_reset_count");
        send_bits(mk_frame(8'hA5, 1'b1, 1'b1), 5);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (rx_if.rd_valid !== 1'b0 || rx_if.rd_data !== 8'h00 || rx_if.fifo_count !== '0 ||
            rx_if.overflow !== 1'b0 || rx_if.frame_err !== 1'b0 || rx_if.state_dbg !== IDLE) begin
            errors++;
            $display("FAIL midreset_outputs: v=%b d=%h c=%0d ov=%b fe=%b st=%0d required 0/00/0/0/0/0",
                     rx_if.rd_valid, rx_if.rd_data, rx_if.fifo_count, rx_if.overflow,
                     rx_if.frame_err, rx_if.state_dbg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        base = err_pulses;
        send_bits(mk_frame(8'h1C, 1'b1, 1'b1), 11);
        repeat (5) @(negedge clk);
        check_count(4'd1, "post_reset_count");
        checks++;
        if (err_pulses != base) begin
            errors++;
            $display("FAIL post_reset_err: pulses=%0d required 0", err_pulses - base);
        end
        pop_expect(8'h1C, "post_reset_pop");
    endtask

    task automatic test_timeout();
        int base;
        base = err_pulses;
        send_bits(mk_frame(8'hFF, 1'b1, 1'b1), 5);
        repeat (TIMEOUT + 50) @(negedge clk);
        checks++;
        if (err_pulses - base != 1 || rx_if.state_dbg !== IDLE) begin
            errors++;
            $display("FAIL timeout: pulses=%0d state=%0d required 1/IDLE", err_pulses - base, rx_if.state_dbg);
        end
        check_count(4'd0, "timeout_count");
        send_bits(mk_frame(8'hF0, 1'b1, 1'b1), 11);
        repeat (5) @(negedge clk);
        check_count(4'd1, "timeout_recover_count");
        pop_expect(8'hF0, "timeout_recover_pop");
    endtask

    task automatic test_full_push_pop();
        logic [7:0] b;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            b = 8'(i);
            send_bits(mk_frame(b, 1'b1, 1'b1), 11);
        end
        send_bits(mk_frame(8'h09, 1'b1, 1'b1), 10);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rx_if.rd_ready = 1'b1;
        @(posedge clk);
        #1;
        check_count(4'd8, "pushpop_count");
        checks++;
        if (rx_if.overflow !== 1'b0) begin
            errors++;
            $display("FAIL pushpop_ovf: overflow=%b required 0", rx_if.overflow);
        end
        @(negedge clk);
        rx_if.rd_ready = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        for (int i = 2; i <= 9; i++) begin
            b = 8'(i);
            pop_expect(b, "pushpop_drain");
        end
    endtask

    // main sequence with a global watchdog
    initial begin
        rx_if.rd_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_good_frame();
        test_bad_frames();
        test_overflow();
        test_mid_frame_reset();
        test_timeout();
        test_full_push_pop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
- Receives PS/2 keyboard frames from the board's ps2_clk/ps2_data pins and checks framing and odd parity.
- Buffers good scan-code bytes in a small FIFO.
- Sits directly upstream of the board top-level logic, which pops bytes for display on seg0..seg7/ledr.
- Everything runs on the system clock; PS/2 lines are treated as asynchronous inputs.

Parameters:
- FIFO_DEPTH, 8, number of buffered bytes; power of 2, minimum 2.
- TIMEOUT_CYCLES, 50000, clk cycles without a ps2_clk falling edge before a partial frame is aborted.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset; 0 = reset.
- ps2_clk  input  1  raw PS/2 clock pin.
- ps2_data  input  1  raw PS/2 data pin.
- rd_ready  input  1  consumer accepts the head byte this cycle.
- rd_valid  output  1  FIFO non-empty.
- rd_data  output  8  head byte, first-word fall-through.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  output  1  sticky: a good byte was dropped because the FIFO was full.
- frame_err  output  1  one-cycle pulse on a bad start/parity/stop bit or on timeout.

Behaviour:
- Reset (rst=0, async):
  - FSM goes to IDLE; bit counter, shift register, timeout counter and FIFO pointers go to 0.
  - Synchronizer flops and the previous-clock register reset to 1.
  - Outputs: rd_valid=0, rd_data=8'h00, fifo_count=0, overflow=0, frame_err=0.
- Input synchronization:
  - ps2_clk and ps2_data each pass through 2 flops.
  - A 3rd register holds the previous synchronized ps2_clk.
  - fall = prev & ~sync_clk.
  - ps2_data is sampled only in cycles where fall=1.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data=0 (start bit) go to DATA with bitcnt=0. On fall with data=1, stay in IDLE, no error.
  - DATA: on fall, shift data into bit[bitcnt] (LSB first) and increment bitcnt. After bitcnt reaches 7, go to PARITY.
  - PARITY: on fall, latch the parity bit and go to STOP.
  - STOP: on fall, the frame is good iff stop==1 and ^{byte,parity}==1 (odd parity).
    - Good frame: push the byte.
    - Bad frame: frame_err=1 for one cycle, no push.
    - Either way, return to IDLE.
- Timeout:
  - The counter clears on every fall and in IDLE; otherwise it increments while state != IDLE.
  - When it reaches TIMEOUT_CYCLES-1: go to IDLE, pulse frame_err, discard the partial byte.
- Latency: the push (wptr update) occurs on the 3rd clk rising edge after the stop-bit falling edge appears at the pin. rd_valid is combinational from the pointers and rises right after that edge.
- FIFO:
  - Pointers are $clog2(DEPTH)+1 bits wide; wrap-around is natural in binary.
  - empty = (wptr==rptr); full = MSBs differ and the rest are equal.
  - Pop happens when rd_valid & rd_ready; popping while empty is ignored.
  - Push while full and not popping: byte dropped, overflow set to 1. overflow stays set until reset.
  - Push and pop in the same cycle:
    - When full, the push is accepted and fifo_count stays unchanged.
    - When empty, only the push happens.
  - rd_data = mem[rptr[low bits]].
- Reset mid-frame: the partial frame is lost. Any stray bits after reset are either ignored in IDLE (data=1) or aborted by the timeout.

Decomposition:
- Package ps2_pkg holds:
  - the state enum (IDLE/DATA/PARITY/STOP);
  - constants START_BIT=0, STOP_BIT=1, DATA_BITS=8.
- One sub-module, ps2_sync_fifo (parameter DEPTH, width 8). It owns the pointers, count, full/empty and overflow; the receiver instantiates it.

Test Plan:
- Send frame 0x1C (parity 0, stop 1) at PS/2 rate ~10 kHz -> after the stop edge plus 3 clk: rd_valid=1, rd_data=8'h1C, fifo_count=1, frame_err never pulses. Pop -> rd_valid=0.
- Send 0x1C with parity=1 -> one frame_err pulse, fifo_count stays 0. Send 0xF0 with stop=0 -> one frame_err pulse, fifo_count stays 0.
- With FIFO_DEPTH=8 and rd_ready=0, send 0x01..0x09 -> fifo_count=8, overflow=1 after the 9th frame. Then 8 pops return 0x01..0x08 in order, and overflow stays 1.
- FIFO full with rd_ready=1 held in the same cycle as the 9th push -> 0x01 popped, 0x09 accepted, fifo_count stays 8, overflow=0.
- Send start + 4 data bits, then idle the clock for TIMEOUT_CYCLES -> one frame_err pulse, FSM back in IDLE. The next full frame 0xF0 is received correctly.
- Assert rst=0 for 2 cycles mid-frame (after 5 bits) -> all outputs at reset values. After release, a complete frame 0x1C is received correctly and fifo_count=1.
